alu_seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider that performs the inverse of the ALU's 4x4 multiply op. It divides an 8-bit product-width dividend by a 4-bit divisor and returns an 8-bit quotient and a 4-bit remainder. It sits beside the combinational ALU and is driven by the same operand sources. Work is gated by an enable input, and each divide is started by a start/busy/done handshake.

---
 rtl/alu_seq_divider.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq_divider.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_divider.sv
// ---------------------------------------------------------------------------
// alu_seq_divider
//
// Multi-cycle unsigned restoring divider, the inverse of the ALU's 4x4
// multiply. It divides a DW-bit dividend by a VW-bit divisor and produces a
// DW-bit quotient and a VW-bit remainder. One quotient bit is resolved per
// enabled clock, so a non-zero divide takes DW enabled cycles after the start.
// A zero divisor skips the iterations and reports all-ones / low dividend bits
// with dz raised after a single enabled cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (clears state and results)
//   en        block enable; 0 freezes every register, including done
//   start     request pulse, accepted only in IDLE with en=1
//   dividend  numerator, captured on an accepted start
//   divisor   denominator, captured on an accepted start
//   busy      high from the accepted-start edge until the done edge
//   done      one-cycle (enabled-cycle) pulse when q/r/dz are valid
//   q         registered quotient, held until the next result or reset
//   r         registered remainder, held until the next result or reset
//   dz        divide-by-zero flag for the current result
// ---------------------------------------------------------------------------
module alu_seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dz
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [VW:0]   pr, pr_nx;
  logic [DW-1:0] sh, sh_nx;
  logic [VW-1:0] dvs, dvs_nx;
  logic          busy_nx, done_nx, dz_nx;
  logic [DW-1:0] q_nx;
  logic [VW-1:0] r_nx;

  logic [VW+1:0] rem_shift;
  logic [VW+1:0] trial;
  logic          trial_neg;
  logic [VW:0]   pr_step;
  logic [DW-1:0] sh_step;

  // One restoring-division step. The partial remainder is always below the
  // divisor, so after shifting in the next dividend bit it is below twice the
  // divisor and fits in VW+1 bits; the extra top bit of the trial difference
  // therefore acts as a clean borrow/sign bit. The shift register drains
  // dividend bits from the top while quotient bits fill in from the bottom,
  // so after DW steps it holds exactly the quotient.
  always_comb begin
    rem_shift = {pr, sh[DW-1]};
    trial     = rem_shift - {2'b00, dvs};
    trial_neg = trial[VW+1];
    if (trial_neg) begin
      pr_step = rem_shift[VW:0];
      sh_step = {sh[DW-2:0], 1'b0};
    end else begin
      pr_step = trial[VW:0];
      sh_step = {sh[DW-2:0], 1'b1};
    end
  end

  // Next-state and next-register logic. Everything defaults to holding so an
  // en=0 cycle freezes the block completely. A zero divisor goes straight
  // from IDLE to DONE with done still low; that first DONE cycle publishes
  // the divide-by-zero result, and the following one (with done high) returns
  // to IDLE. This keeps the zero path out of CALC entirely while still
  // giving a single-cycle done pulse.
  always_comb begin
    state_nx = state;
    count_nx = count;
    pr_nx    = pr;
    sh_nx    = sh;
    dvs_nx   = dvs;
    busy_nx  = busy;
    done_nx  = done;
    dz_nx    = dz;
    q_nx     = q;
    r_nx     = r;

    if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            dvs_nx   = divisor;
            sh_nx    = dividend;
            pr_nx    = '0;
            count_nx = '0;
            busy_nx  = 1'b1;
            if (divisor == '0) begin
              state_nx = DONE;
            end else begin
              state_nx = CALC;
            end
          end
        end

        CALC: begin
          pr_nx    = pr_step;
          sh_nx    = sh_step;
          count_nx = count + 1'b1;
          if (count == CW'(DW - 1)) begin
            q_nx     = sh_step;
            r_nx     = pr_step[VW-1:0];
            dz_nx    = 1'b0;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = DONE;
          end
        end

        DONE: begin
          if (!done) begin
            q_nx    = '1;
            r_nx    = sh[VW-1:0];
            dz_nx   = 1'b1;
            done_nx = 1'b1;
            busy_nx = 1'b0;
          end else begin
            done_nx  = 1'b0;
            state_nx = IDLE;
          end
        end

        default: begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers. Reset is synchronous and wins over en, so
  // an in-flight divide is discarded and the published result is cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      pr    <= '0;
      sh    <= '0;
      dvs   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
      q     <= '0;
      r     <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      pr    <= pr_nx;
      sh    <= sh_nx;
      dvs   <= dvs_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      dz    <= dz_nx;
      q     <= q_nx;
      r     <= r_nx;
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_divider
//
// Directed self-checking bench for alu_seq_divider. Inputs are driven and
// outputs sampled 1 ns after each rising edge. Expected quotients, remainders
// and latencies are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [3:0] r;
  logic       dz;

  int checks;
  int passes;
  int lat;
  int pulses;

  alu_seq_divider #(.DW(8), .VW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .dz       (dz)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the functional inputs for the next edge.
  task automatic applyStimulus(input logic e, input logic s,
                               input logic [7:0] dvd, input logic [3:0] dvs);
    en       = e;
    start    = s;
    dividend = dvd;
    divisor  = dvs;
  endtask

  // One comparison: count it, and report observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Pulse start for one edge, then scramble the operand inputs to show the
  // captured copies are what the divider uses.
  task automatic doStart(input logic [7:0] dvd, input logic [3:0] dvs);
    applyStimulus(1'b1, 1'b1, dvd, dvs);
    step();
    applyStimulus(1'b1, 1'b0, 8'h5A, 4'h3);
  endtask

  // Step until done rises, bounded; lat counts edges taken after the start
  // edge. An expired bound leaves lat at the bound, which the caller's
  // latency check reports.
  task automatic waitDone(input int bound, inout int cyc);
    while (done !== 1'b1 && cyc < bound) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 4'd0);
    step();
    step();
    rst_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_q",    32'(q),    32'd0);
    checkOutput("rst_r",    32'(r),    32'd0);
    checkOutput("rst_dz",   32'(dz),   32'd0);

    $display("[TB] 200 / 7");
    doStart(8'd200, 4'd7);
    checkOutput("t1_busy_T0", 32'(busy), 32'd1);
    checkOutput("t1_done_T0", 32'(done), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      checkOutput("t1_busy_mid", 32'(busy), 32'd1);
      checkOutput("t1_done_mid", 32'(done), 32'd0);
    end
    step();
    checkOutput("t1_done_T8", 32'(done), 32'd1);
    checkOutput("t1_busy_T8", 32'(busy), 32'd0);
    checkOutput("t1_q",       32'(q),    32'd28);
    checkOutput("t1_r",       32'(r),    32'd4);
    checkOutput("t1_dz",      32'(dz),   32'd0);
    applyStimulus(1'b1, 1'b1, 8'd9, 4'd2);
    step();
    applyStimulus(1'b1, 1'b0, 8'd9, 4'd2);
    checkOutput("t1_done_drop",     32'(done), 32'd0);
    checkOutput("t1_start_in_done", 32'(busy), 32'd0);
    step();
    checkOutput("t1_still_idle", 32'(busy), 32'd0);
    checkOutput("t1_q_hold",     32'(q),    32'd28);

    $display("[TB] 255 / 1 then 5 / 9 back-to-back");
    doStart(8'd255, 4'd1);
    lat = 0;
    waitDone(20, lat);
    checkOutput("t2a_lat", 32'(lat), 32'd8);
    checkOutput("t2a_q",   32'(q),   32'd255);
    checkOutput("t2a_r",   32'(r),   32'd0);
    step();
    checkOutput("t2a_done_drop", 32'(done), 32'd0);
    doStart(8'd5, 4'd9);
    checkOutput("t2b_busy", 32'(busy), 32'd1);
    lat = 0;
    waitDone(20, lat);
    checkOutput("t2b_lat", 32'(lat), 32'd8);
    checkOutput("t2b_q",   32'(q),   32'd0);
    checkOutput("t2b_r",   32'(r),   32'd5);
    checkOutput("t2b_dz",  32'(dz),  32'd0);
    step();
    checkOutput("t2b_done_drop", 32'(done), 32'd0);

    $display("[TB] 100 / 0");
    doStart(8'd100, 4'd0);
    lat = 0;
    waitDone(20, lat);
    checkOutput("t3_lat",  32'(lat),  32'd1);
    checkOutput("t3_q",    32'(q),    32'hFF);
    checkOutput("t3_r",    32'(r),    32'd4);
    checkOutput("t3_dz",   32'(dz),   32'd1);
    checkOutput("t3_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'd0, 4'd0);
    step();
    step();
    checkOutput("t3_done_frozen", 32'(done), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'd0, 4'd0);
    step();
    checkOutput("t3_done_drop", 32'(done), 32'd0);
    checkOutput("t3_dz_hold",   32'(dz),   32'd1);

    $display("[TB] 200 / 7 with en stalls and a start while busy");
    doStart(8'd200, 4'd7);
    lat = 0;
    step();
    step();
    lat = 2;
    applyStimulus(1'b1, 1'b1, 8'd15, 4'd15);
    step();
    lat++;
    applyStimulus(1'b0, 1'b0, 8'd15, 4'd15);
    for (int i = 0; i < 3; i++) begin
      step();
      lat++;
    end
    checkOutput("t4_busy_stall", 32'(busy), 32'd1);
    checkOutput("t4_done_stall", 32'(done), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'd15, 4'd15);
    waitDone(30, lat);
    checkOutput("t4_lat", 32'(lat), 32'd11);
    checkOutput("t4_q",   32'(q),   32'd28);
    checkOutput("t4_r",   32'(r),   32'd4);
    checkOutput("t4_dz",  32'(dz),  32'd0);
    step();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      step();
    end
    checkOutput("t4_no_second_op", 32'(pulses), 32'd0);

    $display("[TB] reset mid-divide");
    doStart(8'd200, 4'd7);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_q",    32'(q),    32'd0);
    checkOutput("t5_r",    32'(r),    32'd0);
    checkOutput("t5_dz",   32'(dz),   32'd0);
    doStart(8'd15, 4'd15);
    lat = 0;
    waitDone(20, lat);
    checkOutput("t5_lat", 32'(lat), 32'd8);
    checkOutput("t5_q2",  32'(q),   32'd1);
    checkOutput("t5_r2",  32'(r),   32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
